// File: rtl/nx_fifo_flex.sv
// nx_fifo_flex: single-clock show-ahead FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, write-through-when-full, high-water mark and sticky errors.
module nx_fifo_flex #(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 256,
    parameter bit DATA_RESET = 1'b1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    afull_thresh,
    input  logic [CW-1:0]    aempty_thresh,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    high_water,
    output logic             underflow,
    output logic             overflow,
    output logic [1:0]       err_sticky
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_high_water;
    logic             r_underflow;
    logic             r_overflow;
    logic [1:0]       r_err_sticky;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [CW-1:0]    w_next_count;

    // Pointers wrap by explicit compare so any depth works, not just powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_full    = (r_count == CW'(DEPTH));
    // A write into a full FIFO is still accepted when a read frees the head slot.
    assign w_wr_ok   = wen & ~clear & (~w_full | ren);
    assign w_rd_ok   = ren & ~clear & ~w_empty;
    assign w_ovf_evt = wen & w_full & ~ren & ~clear;
    assign w_unf_evt = ren & w_empty & ~clear;

    // Next occupancy; clear wins over any request.
    always_comb begin
        w_next_count = r_count;
        if (clear) begin
            w_next_count = {CW{1'b0}};
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   w_next_count = r_count + CW'(1);
                2'b01:   w_next_count = r_count - CW'(1);
                default: w_next_count = r_count;
            endcase
        end
    end

    // Pointers, occupancy, high-water mark and error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= {PW{1'b0}};
            r_rptr       <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_high_water <= {CW{1'b0}};
            r_underflow  <= 1'b0;
            r_overflow   <= 1'b0;
            r_err_sticky <= 2'b00;
        end else begin
            r_count     <= w_next_count;
            r_underflow <= w_unf_evt;
            r_overflow  <= w_ovf_evt;
            if (clear) begin
                r_wptr       <= {PW{1'b0}};
                r_rptr       <= {PW{1'b0}};
                r_high_water <= {CW{1'b0}};
                r_err_sticky <= 2'b00;
            end else begin
                if (w_wr_ok) begin
                    r_wptr <= ptr_inc(r_wptr);
                end else begin
                    r_wptr <= r_wptr;
                end
                if (w_rd_ok) begin
                    r_rptr <= ptr_inc(r_rptr);
                end else begin
                    r_rptr <= r_rptr;
                end
                if (w_next_count > r_high_water) begin
                    r_high_water <= w_next_count;
                end else begin
                    r_high_water <= r_high_water;
                end
                r_err_sticky <= r_err_sticky | {w_ovf_evt, w_unf_evt};
            end
        end
    end

    generate
        if (DATA_RESET) begin : g_mem_rst
            // Storage array, zeroed by reset; clear leaves contents alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= {WIDTH{1'b0}};
                    end
                end else if (w_wr_ok) begin
                    r_mem[r_wptr] <= wdata;
                end else begin
                    r_mem[r_wptr] <= r_mem[r_wptr];
                end
            end
        end else begin : g_mem_norst
            // Storage array without reset.
            always_ff @(posedge clk) begin
                if (w_wr_ok) begin
                    r_mem[r_wptr] <= wdata;
                end else begin
                    r_mem[r_wptr] <= r_mem[r_wptr];
                end
            end
        end
    endgenerate

    assign rdata        = w_empty ? {WIDTH{1'b0}} : r_mem[r_rptr];
    assign empty        = w_empty;
    assign full         = w_full;
    // Threshold compares are deliberately combinational so a threshold change acts at once.
    assign almost_full  = (r_count >= afull_thresh);
    assign almost_empty = (r_count <= aempty_thresh);
    assign used_slots   = r_count;
    assign free_slots   = CW'(DEPTH) - r_count;
    assign high_water   = r_high_water;
    assign underflow    = r_underflow;
    assign overflow     = r_overflow;
    assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_nx_fifo_flex.sv
// Directed self-checking bench for nx_fifo_flex at DEPTH=5 (non-power-of-two).
module tb_nx_fifo_flex;

    localparam int DEPTH = 5;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wen, ren, clear;
    logic [WIDTH-1:0] wdata;
    logic [CW-1:0]    afull_thresh, aempty_thresh;
    logic [WIDTH-1:0] rdata;
    logic             empty, full, almost_full, almost_empty;
    logic [CW-1:0]    used_slots, free_slots, high_water;
    logic             underflow, overflow;
    logic [1:0]       err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    nx_fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
        .wdata(wdata), .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .rdata(rdata), .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .used_slots(used_slots), .free_slots(free_slots),
        .high_water(high_water), .underflow(underflow), .overflow(overflow),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_used", 32'(used_slots), 32'd0);
        chk("rst_free", 32'(free_slots), 32'd5);
        chk("rst_hw", 32'(high_water), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clear = 1'b0; wdata = 16'h0000;
        afull_thresh = 3'd4; aempty_thresh = 3'd1;
        #12;
        chk_reset_state();
        rst_n = 1'b1;
        step();

        // Non-power-of-two wrap, with threshold edges checked during fill
        for (int i = 1; i <= 5; i++) begin
            wen = 1'b1; wdata = 16'(i);
            step();
            chk("fill_used", 32'(used_slots), 32'(i));
            chk("fill_head", 32'(rdata), 32'h1);
            chk("fill_aempty", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
            chk("fill_afull", 32'(almost_full), (i >= 4) ? 32'd1 : 32'd0);
        end
        wen = 1'b0;
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_free", 32'(free_slots), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            ren = 1'b1;
            chk("wrap_pop_a", 32'(rdata), 32'(i));
            step();
        end
        ren = 1'b0;
        chk("wrap_used2", 32'(used_slots), 32'd2);
        for (int i = 6; i <= 8; i++) begin
            wen = 1'b1; wdata = 16'(i);
            step();
        end
        wen = 1'b0;
        chk("wrap_full2", 32'(full), 32'd1);
        for (int i = 4; i <= 8; i++) begin
            ren = 1'b1;
            chk("wrap_pop_b", 32'(rdata), 32'(i));
            step();
        end
        ren = 1'b0;
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_rdata0", 32'(rdata), 32'd0);
        chk("wrap_hw", 32'(high_water), 32'd5);
        chk("wrap_unf", 32'(underflow), 32'd0);

        // Full pass-through: simultaneous write+read at full
        for (int i = 1; i <= 5; i++) begin
            wen = 1'b1; wdata = 16'(i * 16'h11);
            step();
        end
        wdata = 16'h00AA; wen = 1'b1; ren = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("pt_pop", 32'(rdata), 32'(i * 16'h11));
            step();
            chk("pt_full", 32'(full), 32'd1);
            chk("pt_ovf", 32'(overflow), 32'd0);
        end
        wen = 1'b0;
        chk("pt_drain0", 32'(rdata), 32'h44); step();
        chk("pt_drain1", 32'(rdata), 32'h55); step();
        for (int i = 0; i < 3; i++) begin
            chk("pt_tail", 32'(rdata), 32'hAA); step();
        end
        ren = 1'b0;
        chk("pt_empty", 32'(empty), 32'd1);
        chk("pt_err", 32'(err_sticky), 32'd0);

        // Overflow then underflow
        for (int i = 1; i <= 5; i++) begin
            wen = 1'b1; wdata = 16'(16'h100 + i);
            step();
        end
        wdata = 16'h0BAD;
        step();
        wen = 1'b0;
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_used", 32'(used_slots), 32'd5);
        step();
        chk("ovf_single", 32'(overflow), 32'd0);
        chk("ovf_sticky", 32'(err_sticky), 32'b10);
        for (int i = 1; i <= 5; i++) begin
            ren = 1'b1;
            chk("ovf_contents", 32'(rdata), 32'(16'h100 + i));
            step();
        end
        step();
        chk("unf_pulse", 32'(underflow), 32'd1);
        ren = 1'b0;
        step();
        chk("unf_single", 32'(underflow), 32'd0);
        chk("unf_sticky", 32'(err_sticky), 32'b11);
        // Write+read on empty: write accepted, read rejected
        wen = 1'b1; ren = 1'b1; wdata = 16'h0077;
        step();
        wen = 1'b0; ren = 1'b0;
        chk("we_used", 32'(used_slots), 32'd1);
        chk("we_unf", 32'(underflow), 32'd1);
        chk("we_rdata", 32'(rdata), 32'h77);

        // Thresholds change combinationally
        afull_thresh = 3'd0; #1;
        chk("thr_afull0", 32'(almost_full), 32'd1);
        afull_thresh = 3'd4;
        wen = 1'b1; wdata = 16'h0078; step();
        wdata = 16'h0079; step();
        wen = 1'b0;
        aempty_thresh = 3'd2; #1;
        chk("thr_aempty_lo", 32'(almost_empty), 32'd0);
        aempty_thresh = 3'd5; #1;
        chk("thr_aempty_depth", 32'(almost_empty), 32'd1);
        afull_thresh = 3'd3; #1;
        chk("thr_afull_hit", 32'(almost_full), 32'd1);
        afull_thresh = 3'd4; #1;
        chk("thr_afull_drop", 32'(almost_full), 32'd0);
        aempty_thresh = 3'd1;

        // Clear priority over simultaneous write/read
        clear = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 16'h0EEE;
        step();
        clear = 1'b0; wen = 1'b0; ren = 1'b0;
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_used", 32'(used_slots), 32'd0);
        chk("clr_hw", 32'(high_water), 32'd0);
        chk("clr_err", 32'(err_sticky), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        step();
        chk("clr_unf2", 32'(underflow), 32'd0);
        wen = 1'b1; wdata = 16'h00C1;
        step();
        wen = 1'b0;
        chk("clr_rw_rdata", 32'(rdata), 32'hC1);
        chk("clr_rw_hw", 32'(high_water), 32'd1);

        // Asynchronous reset between edges
        wen = 1'b1; wdata = 16'h00D1; step();
        wdata = 16'h00D2; step();
        #1;
        rst_n = 1'b0; wen = 1'b0;
        #1;
        chk_reset_state();
        #2;
        rst_n = 1'b1;
        step();
        wen = 1'b1; wdata = 16'h00E1; step();
        wdata = 16'h00E2; step();
        wen = 1'b0; ren = 1'b1;
        chk("post_rst_head0", 32'(rdata), 32'hE1);
        chk("post_rst_used", 32'(used_slots), 32'd2);
        step();
        chk("post_rst_head1", 32'(rdata), 32'hE2);
        step();
        ren = 1'b0;
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nx_fifo_flex.md
# nx_fifo_flex

Parametrised single-clock synchronous FIFO for the nx_library, the next generation of the fixed-depth `nx_fifo`. It adds:
- arbitrary (non-power-of-two) depth;
- runtime-programmable almost-full/almost-empty thresholds;
- write-through-when-full on a simultaneous read;
- a high-water mark;
- sticky error status.

It drops into datapath buffers in the compression/crypto engines wherever `nx_fifo` is used today. It keeps the same show-ahead read semantics.

## Interface
**Parameters**
- `DEPTH`, 4: number of entries; any integer ≥ 2.
- `WIDTH`, 256: data width in bits.
- `DATA_RESET`, 1: 1 = storage array cleared to 0 by `rst_n`; 0 = storage not reset.
- `CW`, `$clog2(DEPTH+1)`: derived count width; not overridden.

**Ports**
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wen`, in, 1: write request.
- `ren`, in, 1: read/pop request.
- `clear`, in, 1: synchronous flush.
- `wdata`, in, WIDTH: write data.
- `afull_thresh`, in, CW: almost-full level.
- `aempty_thresh`, in, CW: almost-empty level.
- `rdata`, out, WIDTH: head entry (show-ahead); 0 when empty.
- `empty`, out, 1: FIFO empty.
- `full`, out, 1: FIFO full.
- `almost_full`, out, 1: `used_slots >= afull_thresh`.
- `almost_empty`, out, 1: `used_slots <= aempty_thresh`.
- `used_slots`, out, CW: occupied entries.
- `free_slots`, out, CW: `DEPTH - used_slots`.
- `high_water`, out, CW: maximum `used_slots` reached since reset/clear.
- `underflow`, out, 1: one-cycle pulse on an illegal read.
- `overflow`, out, 1: one-cycle pulse on a dropped write.
- `err_sticky`, out, 2: {overflow seen, underflow seen}.

## Operation
- Storage: DEPTH×WIDTH register array.
  - Read and write pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0; explicit compare, no power-of-two masking.
  - Occupancy is a CW-bit register `count`.
- Accepted write `wr_ok = wen & ~clear & (~full | ren)`: stores `wdata` at `wptr` and advances `wptr`.
- Accepted read `rd_ok = ren & ~clear & ~empty`: advances `rptr`.
- Count update:
  - `count` +1 on `wr_ok & ~rd_ok`;
  - `count` −1 on `rd_ok & ~wr_ok`;
  - `count` unchanged when both or neither.
- Full with simultaneous `wen` & `ren`: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous `wen` & `ren`: the write is accepted, the read is rejected (underflow pulse), count 0→1.
- `overflow` is registered: 1 the cycle after `wen & full & ~ren & ~clear`.
- `underflow` is registered: 1 the cycle after `ren & empty & ~clear`.
- `err_sticky[1]` latches on overflow and `err_sticky[0]` latches on underflow. Both clear only on `clear` or reset.
- `clear` has priority over `wen`/`ren` in the same cycle. It zeroes both pointers, `count`, `high_water` and `err_sticky`. It does not pulse `underflow`/`overflow` and does not touch the storage contents.
- `high_water <= max(high_water, next_count)` every cycle.
- `empty = (count == 0)`.
- `full = (count == DEPTH)`.
- `free_slots = DEPTH - count`.
- `almost_full`/`almost_empty` are combinational compares of the registered `count` against the threshold inputs.
  - Thresholds may change at any time and take effect immediately.
  - `afull_thresh = 0` forces `almost_full = 1`.
  - `aempty_thresh ≥ DEPTH` forces `almost_empty = 1`.
- `rdata = empty ? 0 : mem[rptr]`, combinational.
- Reset values:
  - `empty = 1`; `full = 0`; `used_slots = 0`; `free_slots = DEPTH`;
  - `high_water = 0`; `underflow = 0`; `overflow = 0`; `err_sticky = 0`; `rdata = 0`;
  - `almost_empty = 1`; `almost_full = (afull_thresh == 0)`;
  - storage is 0 when `DATA_RESET = 1`.
- Reset asserted mid-operation discards all contents immediately and asynchronously; in-flight requests are lost.

## Timing
- Write latency:
  - a word written at edge N is visible on `rdata` and reflected in `empty`, `used_slots`, thresholds and `high_water` in cycle N+1;
  - the minimum write-to-read turnaround is 1 cycle.
- Read: `rdata` shows the head word in the same cycle `ren` is sampled; the pop takes effect at that edge and the next head appears in cycle N+1.
- Status outputs change only on `clk` edges, or on `rst_n` assertion, or combinationally on threshold-input changes.
- Error pulses lag the offending request by exactly 1 cycle and last 1 cycle per offending cycle; back-to-back offences give a continuous high.
- Sustained throughput is 1 write + 1 read per cycle at every occupancy, including full and empty boundaries as defined above.

## Test plan
- **Non-power-of-two wrap.** DEPTH=5. Write 0x1..0x5, giving `full = 1`, `used_slots = 5`, `free_slots = 0`. Read 3 and write 0x6..0x8. Then read all 5 → order 0x4,0x5,0x6,0x7,0x8, `empty = 1`, `rdata = 0`, `high_water = 5`.
- **Full pass-through.** DEPTH=5, full. Assert `wen` & `ren` with `wdata = 0xAA` for 3 cycles → `full` held, `overflow = 0`. The popped words are the oldest 3, and 0xAA is the tail entry.
- **Overflow/underflow.** DEPTH=4.
  - Full, `wen` only → `overflow` 1 the next cycle for 1 cycle, `err_sticky = 2'b10`, contents unchanged.
  - Then drain and pulse `ren` on empty → `underflow` pulse, `err_sticky = 2'b11`.
- **Thresholds.** DEPTH=8, `afull_thresh = 6`, `aempty_thresh = 2`. Fill one word per cycle:
  - `almost_empty` drops in the cycle after the 3rd write;
  - `almost_full` rises in the cycle after the 6th write.
  - Changing `afull_thresh` to 7 while holding 6 entries drops `almost_full` combinationally.
- **Clear priority.** 3 entries, `err_sticky = 2'b01`. `clear`+`wen`+`ren` in one cycle → next cycle `empty = 1`, `used_slots = 0`, `high_water = 0`, `err_sticky = 0`, no error pulse.
- **Async reset.** Assert `rst_n = 0` mid-burst between edges → all outputs reach their reset values without a clock edge. Writes resume correctly after deassertion.
